// File: rtl/fifo_ptr_gen.sv
// fifo_ptr_gen
//   Per-side pointer generator for an asynchronous FIFO. One instance sits
//   in the write domain and one in the read domain. It advances a binary
//   pointer on accepted requests and publishes a registered Gray pointer for
//   the flag logic and the opposite domain. It also drives the RAM address
//   and synchronizes the remote Gray pointer into the local clock domain.
//
// Parameters
//   ADDR_WIDTH  : pointer width including the wrap bit (depth = 2^(ADDR_WIDTH-1))
//   SYNC_STAGES : synchronizer flops on the remote pointer (2..4)
//
// Ports
//   i_clk              : local clock, rising edge
//   i_rst              : synchronous active-high reset
//   i_req              : write request (write side) / read request (read side)
//   i_block            : full (write side) / empty (read side) from the flag stage
//   i_clr_err          : synchronous clear of o_err_sticky
//   i_remote_gray      : Gray pointer from the opposite domain (asynchronous)
//   o_ack              : request accepted this cycle (combinational)
//   o_ptr_bin          : registered binary pointer
//   o_ptr_gray         : registered Gray pointer
//   o_addr_mem         : RAM address (binary pointer without the wrap bit)
//   o_remote_gray_sync : i_remote_gray after SYNC_STAGES local flops
//   o_err_sticky       : set by any request attempted while blocked
module fifo_ptr_gen #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_block,
    input  logic                  i_clr_err,
    input  logic [ADDR_WIDTH-1:0] i_remote_gray,
    output logic                  o_ack,
    output logic [ADDR_WIDTH-1:0] o_ptr_bin,
    output logic [ADDR_WIDTH-1:0] o_ptr_gray,
    output logic [ADDR_WIDTH-2:0] o_addr_mem,
    output logic [ADDR_WIDTH-1:0] o_remote_gray_sync,
    output logic                  o_err_sticky
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0]                  r_ptr_bin;
    logic [ADDR_WIDTH-1:0]                  r_ptr_gray;
    logic                                   r_err;
    logic [SYNC_STAGES-1:0][ADDR_WIDTH-1:0] r_sync;

    logic [ADDR_WIDTH-1:0] w_bin_nxt;
    logic [ADDR_WIDTH-1:0] w_gray_nxt;

    assign o_ack = i_req & ~i_block & ~i_rst;

    // Gray is derived from the incremented binary value and registered, so
    // the published pointer is glitch-free and changes one bit per accept.
    assign w_bin_nxt  = r_ptr_bin + ONE;
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
        end else if (o_ack) begin
            r_ptr_bin  <= w_bin_nxt;
            r_ptr_gray <= w_gray_nxt;
        end
    end

    // Clear beats set, so a clear coinciding with a blocked request leaves 0.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= 1'b0;
        else if (i_clr_err)
            r_err <= 1'b0;
        else if (i_req && i_block)
            r_err <= 1'b1;
    end

    // Plain flop chain: no logic between stages so each bit resolves cleanly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_remote_gray;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sync[i] <= r_sync[i-1];
        end
    end

    assign o_ptr_bin          = r_ptr_bin;
    assign o_ptr_gray         = r_ptr_gray;
    assign o_addr_mem         = r_ptr_bin[ADDR_WIDTH-2:0];
    assign o_remote_gray_sync = r_sync[SYNC_STAGES-1];
    assign o_err_sticky       = r_err;

endmodule

// File: tb/tb_fifo_ptr_gen.sv
module tb_fifo_ptr_gen;

    logic       clk = 1'b0;
    logic       rst, req, block, clr_err;
    logic [7:0] remote;

    logic       ack2, err2, ack3, err3;
    logic [7:0] bin2, gray2, sync2, bin3, gray3, sync3;
    logic [6:0] addr2, addr3;

    int checks = 0;
    int errors = 0;

    // reference model
    int         m_ptr;
    bit         m_err;
    logic [7:0] hist[$];

    always #5 clk = ~clk;

    fifo_ptr_gen #(.ADDR_WIDTH(8), .SYNC_STAGES(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_block(block), .i_clr_err(clr_err),
        .i_remote_gray(remote), .o_ack(ack2), .o_ptr_bin(bin2), .o_ptr_gray(gray2),
        .o_addr_mem(addr2), .o_remote_gray_sync(sync2), .o_err_sticky(err2));

    fifo_ptr_gen #(.ADDR_WIDTH(8), .SYNC_STAGES(3)) u3 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_block(block), .i_clr_err(clr_err),
        .i_remote_gray(remote), .o_ack(ack3), .o_ptr_bin(bin3), .o_ptr_gray(gray3),
        .o_addr_mem(addr3), .o_remote_gray_sync(sync3), .o_err_sticky(err3));

    function automatic logic [7:0] to_gray(int n);
        logic [7:0] b;
        b = 8'(n % 256);
        return b ^ (b >> 1);
    endfunction

    // Value of remote sampled s edges ago, or 0 if a reset intervened.
    function automatic logic [7:0] exp_sync(int s);
        if (hist.size() >= s) return hist[hist.size() - s];
        return 8'h00;
    endfunction

    // Advance one clock edge with the current inputs and update the model.
    task automatic tick();
        bit a;
        a = req && !block && !rst;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0;
            m_err = 0;
            hist.delete();
        end else begin
            if (a) m_ptr = (m_ptr + 1) % 256;
            if (clr_err) m_err = 0;
            else if (req && block) m_err = 1;
            hist.push_back(remote);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; req = 1; block = 0; clr_err = 0; remote = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ack2 !== 1'b0 || ack3 !== 1'b0) begin
                errors++; $display("FAIL reset_ack: got %b/%b want 0", ack2, ack3);
            end
            tick();
        end
        rst = 0; req = 0; remote = 8'h00;
        #1;
        checks++;
        if (bin2 !== 8'h00 || gray2 !== 8'h00 || addr2 !== 7'h00 || err2 !== 1'b0 ||
            sync2 !== 8'h00 || sync3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: bin=%h gray=%h addr=%h err=%b sync2=%h sync3=%h want all 0",
                     bin2, gray2, addr2, err2, sync2, sync3);
        end
    endtask

    task automatic test_single();
        req = 1; block = 0;
        #1;
        checks++;
        if (ack2 !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", ack2); end
        tick();
        req = 0;
        checks++;
        if (bin2 !== 8'h01 || gray2 !== 8'h01 || addr2 !== 7'h01) begin
            errors++;
            $display("FAIL single_ptr: bin=%h gray=%h addr=%h want 01/01/01", bin2, gray2, addr2);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] prev;
        do_reset();
        prev = gray2;
        req = 1; block = 0;
        for (int i = 1; i <= 256; i++) begin
            tick();
            checks++;
            if ($countones(prev ^ gray2) != 1) begin
                errors++; $display("FAIL gray_onebit: %h -> %h at accept %0d", prev, gray2, i);
            end
            checks++;
            if (bin2 !== 8'(m_ptr) || gray2 !== to_gray(m_ptr) || addr2 !== 7'(m_ptr % 128)) begin
                errors++;
                $display("FAIL wrap_model: bin=%h gray=%h addr=%h want %h/%h/%h",
                         bin2, gray2, addr2, 8'(m_ptr), to_gray(m_ptr), 7'(m_ptr % 128));
            end
            if (i == 128) begin
                checks++;
                if (bin2 !== 8'h80 || gray2 !== 8'hC0 || addr2 !== 7'h00) begin
                    errors++; $display("FAIL depth: bin=%h gray=%h addr=%h want 80/C0/00", bin2, gray2, addr2);
                end
            end
            if (i == 255) begin
                checks++;
                if (gray2 !== 8'h80) begin errors++; $display("FAIL pre_wrap: gray=%h want 80", gray2); end
            end
            if (i == 256) begin
                checks++;
                if (bin2 !== 8'h00 || gray2 !== 8'h00) begin
                    errors++; $display("FAIL wrap: bin=%h gray=%h want 00/00", bin2, gray2);
                end
            end
            prev = gray2;
        end
        req = 0;
    endtask

    task automatic test_blocked();
        do_reset();
        req = 1; block = 0;
        repeat (5) tick();
        block = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ack2 !== 1'b0) begin errors++; $display("FAIL blocked_ack: got %b want 0", ack2); end
            tick();
            checks++;
            if (bin2 !== 8'h05) begin errors++; $display("FAIL blocked_hold: bin=%h want 05", bin2); end
        end
        checks++;
        if (err2 !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err2); end
        req = 0; block = 0; clr_err = 1;
        tick();
        checks++;
        if (err2 !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err2); end
        req = 1; block = 1; clr_err = 1;
        tick();
        checks++;
        if (err2 !== 1'b0 || bin2 !== 8'h05) begin
            errors++; $display("FAIL clr_vs_set: err=%b bin=%h want 0/05", err2, bin2);
        end
        req = 0; block = 0; clr_err = 0;
    endtask

    task automatic test_sync();
        remote = 8'h00;
        repeat (4) tick();
        remote = 8'hC0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (sync2 !== ((k >= 2) ? 8'hC0 : 8'h00)) begin
                errors++; $display("FAIL sync2_edge%0d: got %h want %h", k, sync2, (k >= 2) ? 8'hC0 : 8'h00);
            end
            checks++;
            if (sync3 !== ((k >= 3) ? 8'hC0 : 8'h00)) begin
                errors++; $display("FAIL sync3_edge%0d: got %h want %h", k, sync3, (k >= 3) ? 8'hC0 : 8'h00);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        remote = 8'h3C;
        req = 1; block = 0;
        repeat (50) tick();
        checks++;
        if (gray2 !== 8'h2B) begin errors++; $display("FAIL mid_gray: got %h want 2B", gray2); end
        rst = 1;
        #1;
        checks++;
        if (ack2 !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b want 0", ack2); end
        tick();
        checks++;
        if (bin2 !== 8'h00 || gray2 !== 8'h00 || addr2 !== 7'h00 || err2 !== 1'b0 || sync2 !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: bin=%h gray=%h addr=%h err=%b sync=%h want all 0",
                     bin2, gray2, addr2, err2, sync2);
        end
        rst = 0;
        tick();
        req = 0;
        checks++;
        if (bin2 !== 8'h01 || gray2 !== 8'h01) begin
            errors++; $display("FAIL mid_resume: bin=%h gray=%h want 01/01", bin2, gray2);
        end
    endtask

    task automatic test_random();
        bit ea;
        for (int i = 0; i < 400; i++) begin
            rst     = ($urandom_range(0, 31) == 0);
            req     = $urandom_range(0, 1);
            block   = ($urandom_range(0, 3) == 0);
            clr_err = ($urandom_range(0, 7) == 0);
            remote  = 8'($urandom);
            #1;
            ea = req && !block && !rst;
            checks++;
            if (ack2 !== ea || ack3 !== ea) begin
                errors++; $display("FAIL rnd_ack: got %b/%b want %b", ack2, ack3, ea);
            end
            tick();
            checks++;
            if (bin2 !== 8'(m_ptr) || gray2 !== to_gray(m_ptr) || addr2 !== 7'(m_ptr % 128) ||
                err2 !== m_err || bin3 !== 8'(m_ptr)) begin
                errors++;
                $display("FAIL rnd_ptr: bin=%h gray=%h addr=%h err=%b bin3=%h want %h/%h/%h/%b",
                         bin2, gray2, addr2, err2, bin3, 8'(m_ptr), to_gray(m_ptr), 7'(m_ptr % 128), m_err);
            end
            checks++;
            if (sync2 !== exp_sync(2) || sync3 !== exp_sync(3)) begin
                errors++;
                $display("FAIL rnd_sync: got %h/%h want %h/%h", sync2, sync3, exp_sync(2), exp_sync(3));
            end
        end
        rst = 0; req = 0; block = 0; clr_err = 0;
    endtask

    initial begin
        m_ptr = 0; m_err = 0;
        test_reset();
        test_single();
        test_wrap();
        test_blocked();
        test_sync();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_gen.md
# fifo_ptr_gen

Per-side pointer generator for the asynchronous FIFO. One instance runs in the write domain and one in the read domain. Each advances a binary pointer on accepted requests and publishes the registered Gray pointer that the empty/full flag logic consumes. It also provides the RAM address and a multi-flop synchronizer that brings the opposite side's Gray pointer into the local clock domain.

## Interface
Parameters:
- ADDR_WIDTH, 8, pointer width including the wrap bit; FIFO depth = 2^(ADDR_WIDTH-1)
- SYNC_STAGES, 2, number of synchronizer flops for the remote pointer (legal values 2..4)

Ports:
- clk  input  1  local-domain clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  write request (write side) or read request (read side)
- block  input  1  full flag (write side) or empty flag (read side), taken from the flag stage
- clr_err  input  1  synchronous clear of err_sticky
- remote_gray  input  ADDR_WIDTH  Gray pointer from the opposite clock domain (asynchronous)
- ack  output  1  request accepted this cycle
- ptr_bin  output  ADDR_WIDTH  registered binary pointer
- ptr_gray  output  ADDR_WIDTH  registered Gray pointer, fed to the flag stage and to the opposite domain
- addr_mem  output  ADDR_WIDTH-1  RAM address = ptr_bin[ADDR_WIDTH-2:0]
- remote_gray_sync  output  ADDR_WIDTH  remote_gray after SYNC_STAGES local flops
- err_sticky  output  1  set by any request attempted while blocked

## Operation
- ack = req & ~block & ~rst. This is combinational and is the only output not taken directly from a flop.
- On a clk edge where ack = 1:
  - ptr_bin <= ptr_bin + 1, modulo 2^ADDR_WIDTH.
  - ptr_gray <= next ^ (next >> 1), where next is the incremented binary value.
- ptr_gray is computed from the next binary value and registered, never decoded from the current ptr_bin. It therefore never glitches, and successive values differ in exactly one bit.
- Wrap-around: 2^ADDR_WIDTH-1 -> 0. For ADDR_WIDTH=8 this is ptr_bin FF -> 00 and ptr_gray 80 -> 00. Wrap needs no special handling.
- addr_mem drops the wrap bit. ptr_bin 00 and 80 both map to addr_mem 00.
- Blocked request (req = 1, block = 1): the pointer holds, ack = 0, and err_sticky <= 1.
- err_sticky precedence, highest first: rst, then clr_err, then set. If clr_err and a blocked request occur in the same cycle, the result is 0.
- Synchronizer: a chain of SYNC_STAGES flops on remote_gray, with no logic between stages. The last stage drives remote_gray_sync.
- No other state. No FSM beyond the counter.

## Timing
- Reset: on a clk edge with rst = 1, the following become 0: ptr_bin, ptr_gray, addr_mem, err_sticky, and all synchronizer flops (so remote_gray_sync = 0).
  - ack is forced to 0 while rst = 1.
  - Reset takes effect mid-operation regardless of req and block.
- Accept latency: req is sampled at edge N and ptr_bin/ptr_gray show the new value after edge N. The flag stage sees the new ptr_gray one cycle after the accepting edge.
- Throughput: one accept per cycle sustained, as long as block stays 0.
- block is sampled in the same cycle as req. block is produced by the flag stage from registered pointers, so it lags by at least one cycle. The flag stage is responsible for conservative full/empty; this block trusts block.
- Synchronizer latency: a stable remote_gray appears on remote_gray_sync after exactly SYNC_STAGES edges.
- Simultaneous req and rst: reset wins, and the pointer becomes 0.

## Test plan
- Reset: hold rst = 1 for 2 cycles with req = 1 -> after release, ptr_bin = 00, ptr_gray = 00, addr_mem = 00, err_sticky = 0, remote_gray_sync = 00, and ack = 0 throughout the reset.
- Single accept: req = 1, block = 0 for 1 cycle -> ack = 1, then ptr_bin = 01, ptr_gray = 01, addr_mem = 01.
- Depth and wrap: 128 consecutive accepts -> ptr_bin = 80, ptr_gray = C0, addr_mem = 00. Continue to 255 accepts -> ptr_gray = 80. One more accept -> ptr_bin = 00, ptr_gray = 00. A checker asserts a one-bit Gray change on every accept.
- Blocked request: from ptr_bin = 05, drive req = 1, block = 1 for 3 cycles -> ack = 0, pointer stays 05, err_sticky = 1. Then pulse clr_err -> err_sticky = 0. Then clr_err together with a blocked request -> err_sticky stays 0.
- Synchronizer: change remote_gray 00 -> C0, then hold -> remote_gray_sync = 00 for SYNC_STAGES-1 edges and C0 after edge SYNC_STAGES. Check with SYNC_STAGES = 2 and 3.
- Reset mid-stream: after 50 accepts (ptr_gray = 2B), assert rst for 1 cycle while req = 1 -> all outputs 0 on that edge. Accepting resumes from 00 on the next cycle.
